// File: rtl/character_ram_arbiter.sv
// Arbiter for the shared single-port character sprite RAM: two burst readers (A, B), one writer (W).
// Define CHAR_ARB_RR_EN to use a round-robin A/B tie-break; without it, A always wins a tie.
module character_ram_arbiter #(
  parameter int ADDR_W    = 19,
  parameter int DATA_W    = 24,
  parameter int LEN_W     = 8,
  parameter int MEM_DEPTH = 54600
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [LEN_W-1:0]  a_len,
  output logic              a_ack,
  output logic              a_valid,
  output logic [DATA_W-1:0] a_data,
  output logic              a_last,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [LEN_W-1:0]  b_len,
  output logic              b_ack,
  output logic              b_valid,
  output logic [DATA_W-1:0] b_data,
  output logic              b_last,
  input  logic              w_req,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  output logic              w_ack,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_write_address,
  output logic [ADDR_W-1:0] ram_read_address,
  output logic [DATA_W-1:0] ram_data_In,
  input  logic [DATA_W-1:0] ram_data_Out
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BURST_A = 2'd1;
  localparam logic [1:0] BURST_B = 2'd2;
  localparam logic [1:0] WRITE   = 2'd3;

  localparam logic [ADDR_W-1:0] DEPTH     = ADDR_W'(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

  logic [1:0]        state;
  logic [LEN_W-1:0]  count;
  logic [DATA_W-1:0] a_data_q;
  logic [DATA_W-1:0] b_data_q;
  logic              grant_w;
  logic              grant_a;
  logic              grant_b;
`ifdef CHAR_ARB_RR_EN
  logic              last_grant_b;
`endif

  function automatic logic [ADDR_W-1:0] reduce_addr(input logic [ADDR_W-1:0] base);
    return (base >= DEPTH) ? base - DEPTH : base;
  endfunction

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr);
    return (addr == LAST_ADDR) ? '0 : addr + ADDR_W'(1);
  endfunction

  // Only meaningful while IDLE: write first, then a lone reader, then the tie-break.
  always_comb begin
    grant_w = w_req;
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!w_req) begin
      if (a_req && b_req) begin
`ifdef CHAR_ARB_RR_EN
        grant_a = last_grant_b;
        grant_b = !last_grant_b;
`else
        grant_a = 1'b1;
`endif
      end else begin
        grant_a = a_req;
        grant_b = b_req;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state             <= IDLE;
      count             <= '0;
      a_ack             <= 1'b0;
      a_valid           <= 1'b0;
      a_last            <= 1'b0;
      a_data_q          <= '0;
      b_ack             <= 1'b0;
      b_valid           <= 1'b0;
      b_last            <= 1'b0;
      b_data_q          <= '0;
      w_ack             <= 1'b0;
      ram_we            <= 1'b0;
      ram_write_address <= '0;
      ram_read_address  <= '0;
      ram_data_In       <= '0;
`ifdef CHAR_ARB_RR_EN
      last_grant_b      <= 1'b1;
`endif
    end else begin
      a_ack   <= 1'b0;
      b_ack   <= 1'b0;
      w_ack   <= 1'b0;
      ram_we  <= 1'b0;
      a_valid <= 1'b0;
      a_last  <= 1'b0;
      b_valid <= 1'b0;
      b_last  <= 1'b0;
      if (a_valid) a_data_q <= ram_data_Out;
      if (b_valid) b_data_q <= ram_data_Out;

      case (state)
        IDLE: begin
          if (grant_w) begin
            state             <= WRITE;
            ram_we            <= 1'b1;
            ram_write_address <= w_addr;
            ram_data_In       <= w_data;
            w_ack             <= 1'b1;
          end else if (grant_a) begin
            state            <= BURST_A;
            a_ack            <= 1'b1;
            ram_read_address <= reduce_addr(a_addr);
            count            <= a_len;
`ifdef CHAR_ARB_RR_EN
            last_grant_b     <= 1'b0;
`endif
          end else if (grant_b) begin
            state            <= BURST_B;
            b_ack            <= 1'b1;
            ram_read_address <= reduce_addr(b_addr);
            count            <= b_len;
`ifdef CHAR_ARB_RR_EN
            last_grant_b     <= 1'b1;
`endif
          end
        end
        BURST_A, BURST_B: begin
          // The per-client valid flags double as the owner tag of the word in flight.
          if (state == BURST_A) begin
            a_valid <= 1'b1;
            a_last  <= (count == '0);
          end else begin
            b_valid <= 1'b1;
            b_last  <= (count == '0);
          end
          if (count == '0) begin
            state <= IDLE;
          end else begin
            ram_read_address <= next_addr(ram_read_address);
            count            <= count - LEN_W'(1);
          end
        end
        WRITE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The RAM output is already registered; while valid it is forwarded, otherwise the last word is held.
  assign a_data = a_valid ? ram_data_Out : a_data_q;
  assign b_data = b_valid ? ram_data_Out : b_data_q;

endmodule

// File: doc/character_ram_arbiter.md
Name: character_ram_arbiter

Overview:
- Shares the single-port character sprite RAM (24-bit RGB words, 54600 deep, 1-cycle registered read) between two burst-read clients and one write client.
- Client A is the overworld/battle sprite renderer; client B is the menu/text overlay; client W is the sprite loader/patcher.
- Sequences burst address generation, routes returned data to the owning client, and applies write-first, then round-robin, priority.

Parameters:
- ADDR_W, 19, RAM address width
- DATA_W, 24, RAM word width (RGB888)
- LEN_W, 8, burst length field width; a burst is len+1 words (1..256)
- MEM_DEPTH, 54600, number of valid RAM words; burst addresses wrap at this value

Ports:
- Clk  in  1  system clock, all logic on posedge
- Reset  in  1  synchronous, active-high reset
- a_req  in  1  client A burst request; held with a_addr/a_len stable until a_ack
- a_addr  in  ADDR_W  client A burst base address
- a_len  in  LEN_W  client A burst length minus one
- a_ack  out  1  one-cycle pulse: A's request accepted
- a_valid  out  1  a_data holds a returned word
- a_data  out  DATA_W  returned word for A
- a_last  out  1  high with the final a_valid of a burst
- b_req, b_addr, b_len, b_ack, b_valid, b_data, b_last: same as A, for client B
- w_req  in  1  single-word write request; held with w_addr/w_data stable until w_ack
- w_addr  in  ADDR_W  write address
- w_data  in  DATA_W  write data
- w_ack  out  1  one-cycle pulse: the write was performed this cycle
- ram_we  out  1  to RAM we
- ram_write_address  out  ADDR_W  to RAM write_address
- ram_read_address  out  ADDR_W  to RAM read_address
- ram_data_In  out  DATA_W  to RAM data_In
- ram_data_Out  in  DATA_W  from RAM data_Out (valid the cycle after its address is presented)

Behaviour:
- Reset values: all outputs 0; state IDLE; in-flight pipeline cleared; last_grant = B, so A wins the first tie.
- State machine states: IDLE, BURST_A, BURST_B, WRITE.
- All outputs are registered.
- Arbitration happens only in IDLE. Priority at cycle t:
  - w_req wins: WRITE at t+1.
  - Otherwise a single read request wins.
  - Otherwise, with both a_req and b_req, the client not equal to last_grant wins.
- Burst grant at t: at t+1 the state is BURST_x, x_ack=1 for one cycle, ram_read_address=base, and the counter is loaded with len.
- During a burst, one address is issued per cycle: base, base+1, ... base+len, i.e. len+1 cycles.
- Address increment wraps: an address of MEM_DEPTH-1 is followed by 0.
- Any base address >= MEM_DEPTH is reduced to base-MEM_DEPTH before issue.
- After the last issue cycle the state returns to IDLE.
- Read latency: the word for the address issued at cycle n appears on x_data with x_valid=1 at n+1.
- Full timing for a burst granted at t:
  - ack at t+1;
  - first valid at t+2;
  - last valid with x_last at t+2+len;
  - IDLE at t+2+len, so the next grant can issue at t+3+len.
- The in-flight word is tagged with its owner, so a newly granted burst never misroutes it.
- Only the owning client's valid/last/data change; the other client's x_data holds its prior value.
- ram_read_address holds its last value when not issuing.
- Write granted at t: at t+1 the state is WRITE with ram_we=1, ram_write_address=w_addr, ram_data_In=w_data, w_ack=1; IDLE at t+2.
- A write may coincide with the final in-flight read word; that word is still delivered correctly.
- Read-during-write to the same address returns the old data; this matches the RAM.
- Client rule: req must deassert by the cycle after ack. A req still high in IDLE is treated as a new request.
- len=0 produces a one-word burst: x_valid and x_last together at t+2.
- Reset mid-burst or mid-write: everything returns to reset values on the next edge; no further valid/ack pulses; an aborted burst is not resumed.
- last_grant updates only on read grants.

Optional Feature:
- Macro: CHAR_ARB_RR_EN.
- Defined: round-robin tie-break between A and B via last_grant, as above.
- Undefined: fixed priority, A always beats B in a tie; last_grant register removed. Write-first priority is unchanged in both builds.

Test Plan:
- Reset, then a_req with addr=0x100, len=3 -> a_ack at t+1; a_valid at t+2..t+5 returning mem[0x100..0x103]; a_last at t+5; b_* stays 0.
- a_req and b_req asserted together twice in a row, each len=0 -> with CHAR_ARB_RR_EN, grants go A then B; without it, grants go A then A while b_req is held.
- w_req (addr=0x20, data=0xFF00FF) asserted in the same cycle as a_req -> write first: ram_we=1 and w_ack at t+1; A acked at t+3; a subsequent read of 0x20 returns 0xFF00FF.
- a burst with addr=54598, len=3 -> issued addresses 54598, 54599, 0, 1.
- Reset asserted during the 3rd word of a len=7 burst -> no a_valid after the reset edge; state IDLE; next request is served normally.
- back-to-back A burst (len=1) then B burst (len=1) -> A data at t+2/t+3; b_ack at t+4; B data at t+5/t+6; no misrouting.
